// File: rtl/button_pulse_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : button_pulse_conditioner                                      |
// | Purpose  : Sync, debounce and pulse-shape up/down push-buttons, with     |
// |            optional hold-to-auto-repeat, for the BCD digit counter.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module button_pulse_conditioner #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] HOLD_CYCLES     = 24'd5000000,
  parameter logic [23:0] REPEAT_CYCLES   = 24'd2500000,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btnUp,
  input  logic btnDown,
  output logic triggerUp,
  output logic triggerDown,
  output logic upHeld,
  output logic downHeld
);

  localparam int c_debMax  = int'(DEBOUNCE_CYCLES);
  localparam int c_holdMax = int'(HOLD_CYCLES);
  localparam int c_repMax  = int'(REPEAT_CYCLES);
  localparam int c_debW    = $clog2(c_debMax + 1);
  localparam int c_tmrW    = $clog2(((c_holdMax > c_repMax) ? c_holdMax : c_repMax) + 1);

  localparam logic [c_debW-1:0] c_debTerm  = c_debW'(c_debMax - 1);
  localparam logic [c_tmrW-1:0] c_holdTerm = c_tmrW'(c_holdMax - 1);
  localparam logic [c_tmrW-1:0] c_repTerm  = c_tmrW'(c_repMax - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  // Channel 0 is up, channel 1 is down.
  logic [1:0] w_raw;
  logic [1:0] w_want;
  logic [1:0] w_level;
  logic [1:0] w_trig;
  logic       w_freeze;

  assign w_raw    = {btnDown, btnUp};
  assign w_freeze = w_level[0] & w_level[1];

  generate
    for (genvar i = 0; i < 2; i++) begin : g_chan
      logic              r_sync1;
      logic              r_sync2;
      logic              r_level;
      logic [c_debW-1:0] r_debCnt;
      logic [c_tmrW-1:0] r_tmr;
      logic [c_tmrW-1:0] w_tmrNext;
      state_t            r_state;
      state_t            w_stateNext;
      logic              w_wantOwn;
      logic              r_trig;
      logic              w_flip;
      logic              w_rise;
      logic              w_fall;

      // Press/release events fire on the same edge the debounced level flips,
      // so the trigger lands together with the new level.
      assign w_flip = (r_sync2 != r_level) && (r_debCnt == c_debTerm);
      assign w_rise = w_flip && r_sync2;
      assign w_fall = w_flip && !r_sync2;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sync1  <= 1'b0;
          r_sync2  <= 1'b0;
          r_level  <= 1'b0;
          r_debCnt <= '0;
          r_tmr    <= '0;
          r_state  <= S_IDLE;
          r_trig   <= 1'b0;
        end else begin
          r_sync1 <= w_raw[i];
          r_sync2 <= r_sync1;
          if (r_sync2 == r_level) begin
            r_debCnt <= '0;
          end else if (w_flip) begin
            r_debCnt <= '0;
            r_level  <= r_sync2;
          end else begin
            r_debCnt <= r_debCnt + 1'b1;
          end
          r_tmr   <= w_tmrNext;
          r_state <= w_stateNext;
          // Coincident pulses on both channels cancel each other.
          r_trig  <= w_want[i] & ~w_want[1-i] & ~r_trig;
        end
      end

      always_comb begin
        w_stateNext = r_state;
        w_tmrNext   = r_tmr;
        w_wantOwn   = 1'b0;
        case (r_state)
          S_IDLE: begin
            if (w_rise) begin
              w_wantOwn   = 1'b1;
              w_tmrNext   = '0;
              w_stateNext = S_HOLD;
            end
          end
          S_HOLD: begin
            if (w_fall) begin
              w_stateNext = S_IDLE;
            end else if (!w_freeze) begin
              if (r_tmr == c_holdTerm) begin
                if (REPEAT_EN) begin
                  w_wantOwn   = 1'b1;
                  w_tmrNext   = '0;
                  w_stateNext = S_REPEAT;
                end
              end else begin
                w_tmrNext = r_tmr + 1'b1;
              end
            end
          end
          S_REPEAT: begin
            if (w_fall) begin
              w_stateNext = S_IDLE;
            end else if (!w_freeze) begin
              if (r_tmr == c_repTerm) begin
                w_wantOwn = 1'b1;
                w_tmrNext = '0;
              end else begin
                w_tmrNext = r_tmr + 1'b1;
              end
            end
          end
          default: w_stateNext = S_IDLE;
        endcase
      end

      assign w_want[i]  = w_wantOwn;
      assign w_level[i] = r_level;
      assign w_trig[i]  = r_trig;
    end
  endgenerate

  assign triggerUp   = w_trig[0];
  assign triggerDown = w_trig[1];
  assign upHeld      = w_level[0];
  assign downHeld    = w_level[1];

endmodule
`default_nettype wire
